// File: rtl/display_scan.sv
// display_scan -- time-multiplexed LED display driver.
//
// Takes the display bus (six segment bytes, decimal point, colon and four
// mode annunciators) and scans it onto one shared 8-bit segment bus with
// eight one-hot digit enables. The whole bus is snapshotted at the start of
// each frame, so a digit never shows a mix of old and new values.
//
// Each digit slot lasts SLOT_CYCLES clocks. The first BLANK_CYCLES clocks of
// a slot drive everything low to suppress ghosting between digits.
//
// Optional build macro: DISP_ZERO_BLANK_EN enables leading-zero suppression
// on upper10, lower1000 and lower0100.
//
// Ports
//   clock, reset        system clock, synchronous active-high reset
//   enable              scan enable; low parks the scanner and darkens outputs
//   upper10 .. lower0001 segment bytes (bit0=a .. bit6=g, bit7=dp)
//   point               dp of the lower0010 digit
//   col                 colon annunciator (slot 6)
//   AVS, DAY, MAX, TIM  mode annunciators (slot 7)
//   seg                 shared segment bus, active-high
//   dig_sel             one-hot digit enable, active-high
//   frame_pulse         high on the last cycle of slot 7
module display_scan #(
   parameter int SLOT_CYCLES  = 16,
   parameter int BLANK_CYCLES = 2
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       enable,
   input  logic [7:0] upper10,
   input  logic [7:0] upper01,
   input  logic [7:0] lower1000,
   input  logic [7:0] lower0100,
   input  logic [7:0] lower0010,
   input  logic [7:0] lower0001,
   input  logic       point,
   input  logic       col,
   input  logic       AVS,
   input  logic       DAY,
   input  logic       MAX,
   input  logic       TIM,
   output logic [7:0] seg,
   output logic [7:0] dig_sel,
   output logic       frame_pulse
);

   localparam int CNT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLOT_CYCLES - 1);

   typedef struct packed {
      logic [7:0] u10;
      logic [7:0] u01;
      logic [7:0] l1000;
      logic [7:0] l0100;
      logic [7:0] l0010;
      logic [7:0] l0001;
      logic       point;
      logic       col;
      logic [3:0] mode;   // {AVS, DAY, MAX, TIM}
   } snap_t;

   logic [2:0]       slot, slot_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic             capture;
   snap_t            snap, snap_n;
   logic [7:0][7:0]  glyph;
   logic             drive_n;
   logic [7:0]       seg_p0, dig_p0;
   logic             blank_u10, blank_l1000, blank_l0100;

   function automatic logic [7:0] blank_glyph(input logic [7:0] b, input logic blank);
      return blank ? 8'h00 : b;
   endfunction

`ifdef DISP_ZERO_BLANK_EN
   // A "0" glyph is segments a..f lit; the dp bit does not count.
   function automatic logic is_zero_glyph(input logic [7:0] b);
      return b[6:0] == 7'h3F;
   endfunction
`endif

   // Stage p0: scan position and snapshot for the coming cycle
   always_comb begin
      slot_n  = slot;
      cnt_n   = cnt;
      capture = 1'b0;
      if (enable) begin
         capture = (slot == 3'd0) && (cnt == '0);
         if (cnt == CNT_LAST) begin
            cnt_n  = '0;
            slot_n = slot + 3'd1;
         end else begin
            cnt_n = cnt + CNT_W'(1);
         end
      end else begin
         slot_n = '0;
         cnt_n  = '0;
      end
   end

   always_comb begin
      snap_n = snap;
      if (capture) begin
         snap_n.u10   = upper10;
         snap_n.u01   = upper01;
         snap_n.l1000 = lower1000;
         snap_n.l0100 = lower0100;
         snap_n.l0010 = lower0010;
         snap_n.l0001 = lower0001;
         snap_n.point = point;
         snap_n.col   = col;
         snap_n.mode  = {AVS, DAY, MAX, TIM};
      end
   end

`ifdef DISP_ZERO_BLANK_EN
   // Hundreds digit only goes dark if the thousands digit is already dark.
   always_comb begin
      blank_u10   = is_zero_glyph(snap_n.u10);
      blank_l1000 = is_zero_glyph(snap_n.l1000);
      blank_l0100 = blank_l1000 && is_zero_glyph(snap_n.l0100);
   end
`else
   always_comb begin
      blank_u10   = 1'b0;
      blank_l1000 = 1'b0;
      blank_l0100 = 1'b0;
   end
`endif

   always_comb begin
      glyph    = '0;
      glyph[0] = blank_glyph(snap_n.u10, blank_u10);
      glyph[1] = snap_n.u01;
      glyph[2] = blank_glyph(snap_n.l1000, blank_l1000);
      glyph[3] = blank_glyph(snap_n.l0100, blank_l0100);
      glyph[4] = {snap_n.l0010[7] | snap_n.point, snap_n.l0010[6:0]};
      glyph[5] = snap_n.l0001;
      glyph[6] = {7'b0, snap_n.col};
      glyph[7] = {4'b0, snap_n.mode};
   end

   // Outputs are computed from the next scan position so the register
   // lines up with slot/cnt instead of lagging a cycle behind.
   always_comb begin
      drive_n = enable && (int'(cnt_n) >= BLANK_CYCLES);
      seg_p0  = drive_n ? glyph[slot_n] : 8'h00;
      dig_p0  = drive_n ? (8'b1 << slot_n) : 8'h00;
   end

   // Stage p1: registered scan state, snapshot and pins
   always_ff @(posedge clock) begin
      if (reset) begin
         slot    <= '0;
         cnt     <= '0;
         snap    <= '0;
         seg     <= '0;
         dig_sel <= '0;
      end else begin
         slot    <= slot_n;
         cnt     <= cnt_n;
         snap    <= snap_n;
         seg     <= seg_p0;
         dig_sel <= dig_p0;
      end
   end

   assign frame_pulse = enable && (slot == 3'd7) && (cnt == CNT_LAST);

endmodule

// File: tb/tb_display_scan.sv
module tb_display_scan;

   logic       clock = 1'b0;
   logic       reset, enable;
   logic [7:0] upper10, upper01, lower1000, lower0100, lower0010, lower0001;
   logic       point, col, AVS, DAY, MAX, TIM;
   logic [7:0] seg, dig_sel;
   logic       frame_pulse;

   display_scan #(.SLOT_CYCLES(4), .BLANK_CYCLES(1)) dut (
      .clock(clock), .reset(reset), .enable(enable),
      .upper10(upper10), .upper01(upper01), .lower1000(lower1000),
      .lower0100(lower0100), .lower0010(lower0010), .lower0001(lower0001),
      .point(point), .col(col), .AVS(AVS), .DAY(DAY), .MAX(MAX), .TIM(TIM),
      .seg(seg), .dig_sel(dig_sel), .frame_pulse(frame_pulse)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [7:0] seg;
      logic [7:0] dig;
      logic       fp;
   } exp_t;

   exp_t  expq[$];
   string nameq[$];
   int    checks   = 0;
   int    failures = 0;

   // Monitor: every cycle is an output; compare mid-cycle.
   always @(negedge clock) begin
      if (expq.size() > 0) begin
         exp_t  e;
         string n;
         e = expq.pop_front();
         n = nameq.pop_front();
         checks++;
         if (seg !== e.seg || dig_sel !== e.dig || frame_pulse !== e.fp) begin
            failures++;
            $display("FAIL %s: got seg=%h dig_sel=%h fp=%b, want seg=%h dig_sel=%h fp=%b",
                     n, seg, dig_sel, frame_pulse, e.seg, e.dig, e.fp);
         end
      end
   end

   // Push the expectation for the current cycle, then advance one clock.
   task automatic cyc(input logic [7:0] s, input logic [7:0] d, input logic f, input string n);
      expq.push_back('{seg: s, dig: d, fp: f});
      nameq.push_back(n);
      @(posedge clock);
      #1;
   endtask

   function automatic logic [7:0][7:0] pk(input logic [7:0] b0, b1, b2, b3, b4, b5, b6, b7);
      return {b7, b6, b5, b4, b3, b2, b1, b0};
   endfunction

   // One frame (or its first ncyc cycles) with the given per-slot bytes.
   // Optionally changes upper10 at cycle index chg_cyc.
   task automatic frame(input string tag, input logic [7:0][7:0] e, input int ncyc,
                        input int chg_cyc, input logic [7:0] chg_val);
      for (int i = 0; i < ncyc; i++) begin
         int s, c;
         s = i / 4;
         c = i % 4;
         if (i == chg_cyc) upper10 = chg_val;
         if (c == 0)
            cyc(8'h00, 8'h00, 1'b0, $sformatf("%s s%0d c%0d", tag, s, c));
         else
            cyc(e[s], 8'h01 << s, (i == 31), $sformatf("%s s%0d c%0d", tag, s, c));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
      $fatal(1);
   end

   initial begin
      reset = 1'b1; enable = 1'b0;
      upper10 = 8'h06; upper01 = 8'h5B; lower1000 = 8'h4F;
      lower0100 = 8'h66; lower0010 = 8'h6D; lower0001 = 8'h7D;
      point = 1'b0; col = 1'b0; AVS = 1'b0; DAY = 1'b0; MAX = 1'b0; TIM = 1'b0;
      @(posedge clock); #1;
      cyc(8'h00, 8'h00, 1'b0, "reset0");
      cyc(8'h00, 8'h00, 1'b0, "reset1");

      // Basic scan of the six digit bytes
      reset = 1'b0; enable = 1'b1;
      frame("basic1", pk(8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h00, 8'h00), 32, -1, 8'h00);
      frame("basic2", pk(8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h00, 8'h00), 32, -1, 8'h00);

      // Point, colon, annunciators
      point = 1'b1; col = 1'b1; AVS = 1'b1; TIM = 1'b1;
      frame("annun", pk(8'h06, 8'h5B, 8'h4F, 8'h66, 8'hED, 8'h7D, 8'h01, 8'h09), 32, -1, 8'h00);

      // Mid-frame change waits for the next frame
      frame("midchg", pk(8'h06, 8'h5B, 8'h4F, 8'h66, 8'hED, 8'h7D, 8'h01, 8'h09), 32, 12, 8'h7F);
      frame("newfrm", pk(8'h7F, 8'h5B, 8'h4F, 8'h66, 8'hED, 8'h7D, 8'h01, 8'h09), 32, -1, 8'h00);

      // Reset at slot 5 cnt 2 with enable still high
      frame("prerst", pk(8'h7F, 8'h5B, 8'h4F, 8'h66, 8'hED, 8'h7D, 8'h01, 8'h09), 22, -1, 8'h00);
      reset = 1'b1; upper10 = 8'h06;
      cyc(8'h7D, 8'h20, 1'b0, "rst s5c2");
      reset = 1'b0;
      frame("postrst", pk(8'h06, 8'h5B, 8'h4F, 8'h66, 8'hED, 8'h7D, 8'h01, 8'h09), 32, -1, 8'h00);

      // Enable low for 5 cycles in the middle of slot 2
      frame("preen", pk(8'h06, 8'h5B, 8'h4F, 8'h66, 8'hED, 8'h7D, 8'h01, 8'h09), 10, -1, 8'h00);
      enable = 1'b0; lower0001 = 8'h3F;
      cyc(8'h4F, 8'h04, 1'b0, "dis0");
      for (int k = 1; k < 5; k++) cyc(8'h00, 8'h00, 1'b0, $sformatf("dis%0d", k));
      enable = 1'b1;
      frame("reen", pk(8'h06, 8'h5B, 8'h4F, 8'h66, 8'hED, 8'h3F, 8'h01, 8'h09), 32, -1, 8'h00);

      // Leading zeros
      point = 1'b0; col = 1'b0; AVS = 1'b0; TIM = 1'b0;
      upper10 = 8'h3F; lower1000 = 8'h3F; lower0100 = 8'h3F; lower0010 = 8'hBF;
`ifdef DISP_ZERO_BLANK_EN
      frame("zb1", pk(8'h00, 8'h5B, 8'h00, 8'h00, 8'hBF, 8'h3F, 8'h00, 8'h00), 32, -1, 8'h00);
      lower1000 = 8'h06;
      frame("zb2", pk(8'h00, 8'h5B, 8'h06, 8'h3F, 8'hBF, 8'h3F, 8'h00, 8'h00), 32, -1, 8'h00);
`else
      frame("zb1", pk(8'h3F, 8'h5B, 8'h3F, 8'h3F, 8'hBF, 8'h3F, 8'h00, 8'h00), 32, -1, 8'h00);
      lower1000 = 8'h06;
      frame("zb2", pk(8'h3F, 8'h5B, 8'h06, 8'h3F, 8'hBF, 8'h3F, 8'h00, 8'h00), 32, -1, 8'h00);
`endif

      #20;
      checks++;
      if (expq.size() != 0) begin
         failures++;
         $display("FAIL drain: %0d expectations left, want 0", expq.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
